// File: rtl/ysyx_220066_lsu.sv
// Load/store unit between the ysyx_220066 core and a 64-bit, 8-byte-aligned data memory.
// Define YSYX_220066_LSU_MISALIGN_EN to reject misaligned h/w/d accesses with resp_err.
module ysyx_220066_lsu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e            state_q;
  logic              wr_q;
  logic [2:0]        op_q;
  logic [2:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;

  logic              misalign;
  logic              req_err;
  logic [2:0]        off;
  logic [5:0]        shamt;
  logic [DATA_W-1:0] size_mask;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign req_ready = (state_q == StIdle);

  always_comb begin
    misalign = 1'b0;
`ifdef YSYX_220066_LSU_MISALIGN_EN
    unique case (req_op[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      2'b11:   misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
`endif
    req_err = (req_op == 3'b111) || (req_wr && req_op[2]) || misalign;
  end

  // Low address bits below the access size are dropped, so the lane is always naturally aligned.
  always_comb begin
    off       = 3'b000;
    size_mask = '1;
    unique case (op_q[1:0])
      2'b00: begin
        off       = addr_lo_q;
        size_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
      end
      2'b01: begin
        off       = {addr_lo_q[2:1], 1'b0};
        size_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      end
      2'b10: begin
        off       = {addr_lo_q[2], 2'b00};
        size_mask = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: begin
        off       = 3'b000;
        size_mask = '1;
      end
    endcase
    shamt     = {off, 3'b000};
    lane      = mem_rdata >> shamt;
    byte_mask = size_mask << shamt;
    merged    = (mem_rdata & ~byte_mask) | ((wdata_q << shamt) & byte_mask);
    unique case (op_q)
      3'b000:  load_data = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      3'b010:  load_data = {{(DATA_W-32){lane[31]}}, lane[31:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, lane[7:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, lane[15:0]};
      3'b110:  load_data = {{(DATA_W-32){1'b0}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_q       <= 1'b0;
      op_q       <= 3'b000;
      addr_lo_q  <= 3'b000;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wr_q       <= req_wr;
            op_q       <= req_op;
            addr_lo_q  <= req_addr[2:0];
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end else begin
              resp_err  <= 1'b0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
              if (req_wr && req_op == 3'b011) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
                state_q   <= StWr;
              end else begin
                mem_we  <= 1'b0;
                state_q <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (mem_ready) begin
            if (wr_q) begin
              mem_we    <= 1'b1;
              mem_wdata <= merged;
              state_q   <= StWr;
            end else begin
              mem_valid  <= 1'b0;
              resp_rdata <= load_data;
              resp_valid <= 1'b1;
              state_q    <= StResp;
            end
          end
        end
        StWr: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Directed, table-driven bench for ysyx_220066_lsu with a stall-capable single-word memory model.
module tb_ysyx_220066_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_op;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_220066_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mword;
    int          stall;
    int          lat;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] wword;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic wr, logic [2:0] op, logic [63:0] addr,
                              logic [63:0] wdata, logic [63:0] mword, int stall, int lat,
                              logic [63:0] rdata, logic err, logic [63:0] wword);
    vec_t v;
    v.name = name; v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata; v.mword = mword;
    v.stall = stall; v.lat = lat; v.rdata = rdata; v.err = err; v.wword = wword;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t x);
    int          stall;
    int          lat;
    bit          got;
    bit          seen_mem;
    bit          bad_addr;
    bit          wrote;
    logic [63:0] wword;
    logic [63:0] rdata;
    logic        err;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = x.wr;
    req_op    = x.op;
    req_addr  = x.addr;
    req_wdata = x.wdata;
    mem_rdata = x.mword;
    stall     = x.stall;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; got = 0; seen_mem = 0; bad_addr = 0; wrote = 0; wword = '0; rdata = '0; err = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      if (mem_valid) begin
        seen_mem = 1;
        if (mem_addr !== {x.addr[63:3], 3'b000}) bad_addr = 1;
        if (mem_we) begin
          wrote = 1;
          wword = mem_wdata;
        end
        mem_ready = (stall == 0);
        if (stall > 0) stall--;
      end
      if (resp_valid) begin
        got   = 1;
        lat   = k;
        rdata = resp_rdata;
        err   = resp_err;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    mem_ready = 1'b1;
    chk({x.name, " latency"}, 64'(lat), 64'(x.lat));
    chk({x.name, " rdata"}, rdata, x.rdata);
    chk({x.name, " err"}, 64'(err), 64'(x.err));
    chk({x.name, " mem traffic"}, 64'(seen_mem), 64'(!x.err));
    chk({x.name, " mem_addr"}, 64'(bad_addr), 64'd0);
    if (x.wr && !x.err) begin
      chk({x.name, " wrote"}, 64'(wrote), 64'd1);
      chk({x.name, " mem_wdata"}, wword, x.wword);
    end
    @(posedge clk);
    #1;
    chk({x.name, " pulse end"}, {62'd0, resp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b000; req_addr = '0;
    req_wdata = '0; mem_ready = 1'b1; mem_rdata = '0;

    vecs.push_back(mk("lb", 0, 3'b000, 64'h1007, 0, 64'h8877_6655_4433_2211, 0, 2,
                      64'hFFFF_FFFF_FFFF_FF88, 0, 0));
    vecs.push_back(mk("lbu", 0, 3'b100, 64'h1007, 0, 64'h8877_6655_4433_2211, 0, 2,
                      64'h88, 0, 0));
    vecs.push_back(mk("sh", 1, 3'b001, 64'h2002, 64'hABCD, 64'h1111_1111_1111_1111, 0, 3,
                      0, 0, 64'h1111_1111_ABCD_1111));
    vecs.push_back(mk("ld stall", 0, 3'b011, 64'h3000, 0, 64'h0123_4567_89AB_CDEF, 4, 6,
                      64'h0123_4567_89AB_CDEF, 0, 0));
`ifdef YSYX_220066_LSU_MISALIGN_EN
    vecs.push_back(mk("lw mis", 0, 3'b010, 64'h4002, 0, 64'h1122_3344_99AA_BBCC, 0, 1,
                      0, 1, 0));
    vecs.push_back(mk("lh mis", 0, 3'b001, 64'h6007, 0, 64'h8877_6655_4433_2211, 0, 1,
                      0, 1, 0));
`else
    vecs.push_back(mk("lw mis", 0, 3'b010, 64'h4002, 0, 64'h1122_3344_99AA_BBCC, 0, 2,
                      64'hFFFF_FFFF_99AA_BBCC, 0, 0));
    vecs.push_back(mk("lh mis", 0, 3'b001, 64'h6007, 0, 64'h8877_6655_4433_2211, 0, 2,
                      64'hFFFF_FFFF_FFFF_8877, 0, 0));
`endif
    vecs.push_back(mk("st op100", 1, 3'b100, 64'h4000, 64'h55, 64'h0, 0, 1, 0, 1, 0));
    vecs.push_back(mk("ld op111", 0, 3'b111, 64'h4000, 0, 64'h0, 0, 1, 0, 1, 0));
    vecs.push_back(mk("sd", 1, 3'b011, 64'h5008, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 2,
                      0, 0, 64'hDEAD_BEEF_CAFE_F00D));
    vecs.push_back(mk("lhu", 0, 3'b101, 64'h6006, 0, 64'h8877_6655_4433_2211, 0, 2,
                      64'h8877, 0, 0));
    vecs.push_back(mk("lh", 0, 3'b001, 64'h6006, 0, 64'h8877_6655_4433_2211, 0, 2,
                      64'hFFFF_FFFF_FFFF_8877, 0, 0));
    vecs.push_back(mk("sb", 1, 3'b000, 64'h7005, 64'h5A, 64'h0, 0, 3,
                      0, 0, 64'h0000_5A00_0000_0000));
    vecs.push_back(mk("sw", 1, 3'b010, 64'h7004, 64'hFFFF_FFFF_1234_5678,
                      64'hAAAA_AAAA_BBBB_BBBB, 0, 3, 0, 0, 64'h1234_5678_BBBB_BBBB));
    vecs.push_back(mk("lwu", 0, 3'b110, 64'h8004, 0, 64'h89AB_CDEF_0123_4567, 0, 2,
                      64'h89AB_CDEF, 0, 0));
    vecs.push_back(mk("lw", 0, 3'b010, 64'h8004, 0, 64'h89AB_CDEF_0123_4567, 0, 2,
                      64'hFFFF_FFFF_89AB_CDEF, 0, 0));
    vecs.push_back(mk("sh stall", 1, 3'b001, 64'h9006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 2, 5,
                      0, 0, 64'h1234_FFFF_FFFF_FFFF));

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset resp", {62'd0, resp_valid, resp_err}, 64'd0);
    chk("reset resp_rdata", resp_rdata, 64'd0);
    chk("reset mem ctl", {62'd0, mem_valid, mem_we}, 64'd0);
    chk("reset mem_addr", mem_addr, 64'd0);
    chk("reset mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during a stalled write abandons the access without a response.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_op = 3'b011; req_addr = 64'hA000;
    req_wdata = 64'h1; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst-in-wr writing", {62'd0, mem_valid, mem_we}, 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst-in-wr after", {61'd0, mem_valid, req_ready, resp_valid}, 64'd2);
    mem_ready = 1'b1;
    begin
      bit pulsed = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        if (resp_valid) pulsed = 1;
      end
      chk("rst-in-wr no resp", 64'(pulsed), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
